// File: rtl/imm_instr_sequencer.sv
// Fetch/decode/execute sequencer for immediate-class instructions (MVI_x, MVI_ADD_x).
// Optional single-step gating of instruction starts is enabled with `define SEQ_STEP_EN.
module imm_instr_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        ir,
  input  logic [1:0]        dec_state_control,
  input  logic [3:0]        dec_dest_flag,
  input  logic [1:0]        dec_bank_sel,
  output logic [7:0]        imm,
  output logic [1:0]        bank_out_sel,
  output logic              add_en,
  output logic [3:0]        reg_we,
  output logic              other_start,
  input  logic              other_done,
`ifdef SEQ_STEP_EN
  input  logic              step,
`endif
  output logic              busy
);

  localparam logic [1:0] SC_MVI     = 2'b01;
  localparam logic [1:0] SC_MVI_ADD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    DECODE,
    FETCH_IMM,
    WRITE,
    DISPATCH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        dest;
  logic              go;
  logic              cont;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  // In step mode every instruction starts on a step pulse and ends in IDLE.
`ifdef SEQ_STEP_EN
  assign go   = run && step;
  assign cont = 1'b0;
`else
  assign go   = run;
  assign cont = run;
`endif

  assign mem_addr = pc;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    reg_we      = 4'b0000;
    other_start = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_nxt = FETCH_OP;
      end
      FETCH_OP: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = DECODE;
      end
      DECODE: begin
        if (dec_state_control == SC_MVI || dec_state_control == SC_MVI_ADD) begin
          state_nxt = FETCH_IMM;
        end else begin
          other_start = 1'b1;
          state_nxt   = DISPATCH;
        end
      end
      FETCH_IMM: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = WRITE;
      end
      WRITE: begin
        reg_we    = dest;
        state_nxt = cont ? FETCH_OP : IDLE;
      end
      DISPATCH: begin
        if (other_done) state_nxt = cont ? FETCH_OP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PC is left untouched outside the two fetch states; the general executor owns it in DISPATCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      ir           <= 8'h00;
      imm          <= 8'h00;
      dest         <= 4'b0000;
      bank_out_sel <= 2'b00;
      add_en       <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        DECODE: begin
          if (dec_state_control == SC_MVI) begin
            dest   <= dec_dest_flag;
            add_en <= 1'b0;
          end else if (dec_state_control == SC_MVI_ADD) begin
            bank_out_sel <= dec_bank_sel;
            dest         <= onehot(dec_bank_sel);
            add_en       <= 1'b1;
          end
        end
        FETCH_IMM: begin
          if (mem_ack) begin
            imm <= mem_rdata;
            pc  <= pc + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imm_instr_sequencer.md
Name: imm_instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the immediate-class instructions (MVI_x, MVI_ADD_x) of the 8-bit processor.
- Fetches the opcode byte from program memory over a req/ack handshake and presents it to the combinational memory decoder. Uses the decoder's state_control to fetch the immediate byte and drive register-bank write enables or the add path.
- Non-immediate opcodes are handed off to the rest of the controller via a start/done handshake.

Parameters:
- ADDR_W, 8, program-counter / program-memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- mem_req  output  1  program-memory read request.
- mem_addr  output  ADDR_W  program-memory read address (current PC).
- mem_ack  input  1  read data valid this cycle.
- mem_rdata  input  8  program-memory read data.
- ir  output  8  latched opcode, drives decoder opcode input.
- dec_state_control  input  2  from decoder: 01 = MVI, 10 = MVI_ADD, other = not immediate-class.
- dec_dest_flag  input  4  from decoder, one-hot destination register (A,B,C,D = bit0..3).
- dec_bank_sel  input  2  from decoder, source bank register for MVI_ADD.
- imm  output  8  latched immediate byte.
- bank_out_sel  output  2  register-bank read select.
- add_en  output  1  1 = bank write data is bank_out + imm (8-bit wrap), 0 = imm.
- reg_we  output  4  one-hot register-bank write enable, one-cycle pulse.
- other_start  output  1  one-cycle pulse handing ir to the general executor.
- other_done  input  1  general executor finished, one-cycle pulse.
- busy  output  1  1 in every state except IDLE.

Behaviour:
- Reset (async): state=IDLE, PC=RESET_PC, ir=0, imm=0, mem_req=0, bank_out_sel=0, add_en=0, reg_we=0, other_start=0.
- Reset mid-operation aborts everything and drops mem_req immediately. No register write may occur in the reset cycle.
- States: IDLE, FETCH_OP, DECODE, FETCH_IMM, WRITE, DISPATCH.
- IDLE: if run=1, go to FETCH_OP next cycle.
- FETCH_OP: mem_req=1, mem_addr=PC, both held stable until mem_ack.
  - On mem_ack: ir<=mem_rdata, PC<=PC+1, mem_req low next cycle, go to DECODE.
- DECODE: one cycle, decoder outputs sampled here.
  - state_control 01: latch dest=dec_dest_flag, add_en<=0.
  - state_control 10: bank_out_sel<=dec_bank_sel, dest<=one-hot(dec_bank_sel), add_en<=1.
  - Either case goes to FETCH_IMM.
  - Other state_control: pulse other_start, go to DISPATCH.
- FETCH_IMM: same handshake as FETCH_OP. On mem_ack: imm<=mem_rdata, PC<=PC+1, go to WRITE.
- WRITE: reg_we=dest for exactly one cycle.
  - MVI_ADD writes back to its source register: the result is (bank_out+imm) mod 256 and carry is discarded.
  - Next state is FETCH_OP if run=1, else IDLE.
- DISPATCH: wait for other_done.
  - The general executor owns the PC in this state; the sequencer does not modify it.
  - On other_done: FETCH_OP if run=1, else IDLE.
- Timing: mem_ack may arrive the same cycle mem_req rises (zero-wait memory).
  - Minimum MVI latency with zero-wait memory: 4 cycles (FETCH_OP, DECODE, FETCH_IMM, WRITE).
- PC wraps from 2^ADDR_W-1 to 0 silently. An immediate byte located at address 0 after the wrap is legal.
- run falling mid-instruction does not abort; the instruction completes, then the sequencer enters IDLE.
- mem_ack while mem_req=0 is ignored.
- bank_out_sel and add_en hold their values until the next DECODE.

Optional Feature:
- Macro SEQ_STEP_EN adds input port step (1 bit, one-cycle pulse).
  - With the macro, IDLE→FETCH_OP additionally requires step=1, and every instruction returns to IDLE after completion, regardless of run.
  - Without the macro there is no step port, and execution is free-running under run.

Test Plan:
- Reset with RESET_PC=0x10, run=1, zero-wait memory holding MVI_B,0x5A at 0x10/0x11 → reg_we=0010 for one cycle with add_en=0, imm=0x5A, 4 cycles after leaving IDLE; PC=0x12.
- MVI_ADD_C,0xF0 with C=0x20 → bank_out_sel=10, add_en=1, reg_we=0100, written value 0x10 (wrapped); PC advances by 2.
- 3-wait-state memory (mem_ack 3 cycles after req) → mem_req and mem_addr stable throughout; MVI completes in 10 cycles.
- Non-immediate opcode at PC 0x20 → one other_start pulse, no reg_we; other_done after 5 cycles returns to FETCH_OP at PC 0x21.
- PC=0xFF holding MVI_A, immediate 0x33 at 0x00 → reg_we=0001 with imm=0x33; PC=0x01.
- Assert rst during FETCH_IMM → mem_req=0, reg_we=0 immediately; after release, fetch restarts at RESET_PC. Drop run during WRITE → instruction completes, then IDLE with busy=0.
